ff_operand_feeder: RTL
======================

FF_OPERAND_FEEDER -- requirements
Module: ff_operand_feeder

Interface
REQ-001 The block SHALL have parameter WEIGHT, default 8, giving the operand word width in bits.
REQ-002 The block SHALL have parameter N, default 21, giving the number of words per operand stream.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the load triple is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the buffer can accept a triple.
REQ-007 The block SHALL have ports in_a, in_b and in_g, input, WEIGHT bits each: one word of operand a, b and modulus g.
REQ-008 The block SHALL have port start, input, 1 bit: the request to stream the buffered operands.
REQ-009 The block SHALL have port ctr, output, 1 bit: the control line to the systolic multiplier.
REQ-010 The block SHALL have ports ai, bi and gi, output, bits [WEIGHT:1] each: the word streams to the multiplier.
REQ-011 The block SHALL have port busy, output, 1 bit: high while streaming.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse at the end of streaming.

Function
REQ-013 The block SHALL use states IDLE, FULL, PLAY and FLUSH.
REQ-014 IDLE: in_ready SHALL be 1; each cycle with in_valid=1 SHALL store (in_a,in_b,in_g) at write index w (0..N-1) and increment w. Word 0 is the most-significant word and is streamed first.
REQ-015 In IDLE, accepting the triple at w=N-1 SHALL move the state to FULL and reset w to 0.
REQ-016 FULL: in_ready SHALL be 0, and in_valid SHALL be ignored with no overwrite.
REQ-017 A start sampled high in FULL SHALL move the state to PLAY. A start in IDLE, PLAY or FLUSH SHALL be ignored.
REQ-018 All outputs except in_ready SHALL be registered. Let P0 be the cycle after the edge that samples start.
REQ-019 P0: bi=b[0], ai=0, gi=0, ctr=0.
REQ-020 Pk, k=1..N-1: bi=b[k], ai=a[k-1], gi=g[k-1], ctr=1. The b stream leads a and g by exactly one cycle.
REQ-021 PN: bi=0, ai=a[N-1], gi=g[N-1], ctr=1. The state then moves to FLUSH.
REQ-022 P(N+1), the FLUSH cycle: ai=bi=gi=0, ctr=1, done=1. The state then moves to IDLE with w=0.
REQ-023 After P(N+1): ctr=0, done=0, and ai=bi=gi=0.
REQ-024 busy SHALL be 1 for cycles P0..P(N+1) inclusive and 0 otherwise.
REQ-025 The read index SHALL count 0..N and SHALL never wrap within one play. Buffer contents SHALL be retained after play but overwritten by the next load.
REQ-026 If start and in_valid are both high in FULL, start SHALL win and the load SHALL be ignored.

Reset
REQ-027 While rst=1, asynchronously: state=IDLE, w=0, read index=0, ai=bi=gi=0, ctr=0, busy=0, done=0.
REQ-028 In IDLE, in_ready=1 with no clock edge needed.
REQ-029 Reset asserted mid-load or mid-play SHALL abort immediately; the next operation SHALL require a full reload of N triples.
REQ-030 Buffer storage need not be cleared by reset.

Verification
REQ-031 Load: load a_k=k, b_k=0x40+k, g_k=0x80+k for k=0..20, then pulse start -> P0: bi=0x40, ai=0x00, gi=0x00, ctr=0. P1: bi=0x41, ai=0x00, gi=0x80, ctr=1. P20: bi=0x54, ai=0x13, gi=0x93. P21: bi=0x00, ai=0x14, gi=0x94. P22: all zero, done=1. P23: ctr=0, busy=0.
REQ-032 Backpressure: after 21 accepted triples, hold in_valid=1 with in_a=0xFF -> in_ready=0; streamed data matches the first 21 triples only.
REQ-033 Early start: pulse start after 10 loaded triples -> no output change, busy=0; loading continues to 21 and a later start streams correctly.
REQ-034 Reset mid-play: assert rst during P7 -> all outputs 0 asynchronously, in_ready=1; a new start without reload is ignored.
REQ-035 Simultaneous events: start=1 and in_valid=1 in FULL -> PLAY begins and the buffer is unchanged (P1 gi=0x80).
REQ-036 Back-to-back: a second load of 21 triples after done, then start -> identical skew timing with the new data, and ctr=0 at the new P0.

Source files
------------

// File: rtl/ff_operand_feeder.sv
// ff_operand_feeder: buffers N operand triples (a, b, g) and streams them to a
// systolic multiplier. The b stream leads a and g by one cycle, and a flush
// cycle with done=1 ends each play.
module ff_operand_feeder #(
  parameter int WEIGHT = 8,
  parameter int N      = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WEIGHT-1:0] in_a,
  input  logic [WEIGHT-1:0] in_b,
  input  logic [WEIGHT-1:0] in_g,
  input  logic              start,
  output logic              ctr,
  output logic [WEIGHT:1]   ai,
  output logic [WEIGHT:1]   bi,
  output logic [WEIGHT:1]   gi,
  output logic              busy,
  output logic              done
);

  // The read index must reach N, so both indices share this width.
  localparam int IW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FULL  = 2'd1,
    PLAY  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state, state_d;

  logic [IW-1:0] w, w_d;        // write index while loading
  logic [IW-1:0] r, r_d;        // read index while playing, counts 0..N
  logic [IW-1:0] r_nxt;
  logic          load_en;

  logic [WEIGHT-1:0] ai_d, bi_d, gi_d;
  logic              ctr_d, busy_d, done_d;

  // Entry N is never written; it only keeps the array depth matched to IW.
  logic [WEIGHT-1:0] a_mem [0:N];
  logic [WEIGHT-1:0] b_mem [0:N];
  logic [WEIGHT-1:0] g_mem [0:N];

  // The buffer accepts only in IDLE; asynchronous reset forces IDLE.
  assign in_ready = (state == IDLE);
  assign r_nxt    = r + IW'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state, index and next-output logic.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d = state;
    w_d     = w;
    r_d     = r;
    load_en = 1'b0;
    ai_d    = '0;
    bi_d    = '0;
    gi_d    = '0;
    ctr_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load_en = 1'b1;
          if (w == IW'(N - 1)) begin
            state_d = FULL;
            w_d     = '0;
          end else begin
            w_d = w + IW'(1);
          end
        end
      end
      FULL: begin
        // start wins over in_valid: nothing is written outside IDLE.
        if (start) begin
          state_d = PLAY;
          r_d     = '0;
          bi_d    = b_mem[0];
          busy_d  = 1'b1;
        end
      end
      PLAY: begin
        busy_d = 1'b1;
        ctr_d  = 1'b1;
        if (r == IW'(N)) begin
          state_d = FLUSH;
          done_d  = 1'b1;
        end else begin
          r_d  = r_nxt;
          ai_d = a_mem[r];
          gi_d = g_mem[r];
          if (r != IW'(N - 1)) bi_d = b_mem[r_nxt];
        end
      end
      FLUSH: begin
        state_d = IDLE;
        r_d     = '0;
        w_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Indices and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w    <= '0;
      r    <= '0;
      ai   <= '0;
      bi   <= '0;
      gi   <= '0;
      ctr  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      w    <= w_d;
      r    <= r_d;
      ai   <= ai_d;
      bi   <= bi_d;
      gi   <= gi_d;
      ctr  <= ctr_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Operand buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; the FSM never reads a word that has not
    // been rewritten since reset, and leaving it out keeps it a plain RAM.
    if (load_en) begin
      a_mem[w] <= in_a;
      b_mem[w] <= in_b;
      g_mem[w] <= in_g;
    end
  end

endmodule
